smg_scan_sched: RTL and testbench
=================================

SMG_SCAN_SCHED -- requirements
Module: smg_scan_sched

Interface
REQ-001 SHALL have parameter T_PHASE, default 16'd6249, meaning PWM phase period in CLK cycles minus one (8 phases = one 1 ms digit slot at 50 MHz).
REQ-002 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port RSTn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port Load_Valid  input  1  writer offers a new frame.
REQ-005 SHALL have port Load_Data  input  24  six 4-bit digit codes, digit0 = [23:20] ... digit5 = [3:0].
REQ-006 SHALL have port Load_Dp  input  6  decimal point per digit, bit5 = digit0.
REQ-007 SHALL have port Load_Ready  output  1  shadow buffer free; transfer occurs when Load_Valid & Load_Ready.
REQ-008 SHALL have port Bright  input  3  brightness: digit lit for Bright+1 of 8 phases.
REQ-009 SHALL have port Lz_En  input  1  leading-zero suppression enable.
REQ-010 SHALL have port Scan_En  input  1  display enable; low forces all digits off, scanning continues.
REQ-011 SHALL have port Dig_Sel  output  6  digit select, active-low one-hot, bit0 = digit0.
REQ-012 SHALL have port Number_Data  output  4  code of currently selected digit.
REQ-013 SHALL have port Dp_Out  output  1  decimal point of currently selected digit.
REQ-014 SHALL have port Frame_Start  output  1  one-cycle pulse when digit0 slot begins.

Function
REQ-015 Phase counter SHALL count 0..T_PHASE; phase tick when count == T_PHASE, then wrap to 0.
REQ-016 Phase index (3 bit) SHALL increment on each phase tick, wrapping 7 -> 0.
REQ-017 Slot index SHALL advance on phase tick with phase index == 7: 0->1->2->3->4->5->0; values 6..15 unreachable, SHALL recover to 0.
REQ-018 Frame boundary SHALL be the slot advance 5 -> 0; Frame_Start SHALL pulse high exactly the cycle after it.
REQ-019 Handshake: on Load_Valid & Load_Ready, Load_Data/Load_Dp SHALL be captured to shadow, pending set, Load_Ready low next cycle.
REQ-020 At frame boundary with pending set, shadow SHALL copy to active buffer, pending clear, Load_Ready high next cycle.
REQ-021 Accept in the same cycle as a frame boundary (pending clear) SHALL be held in shadow until the following boundary.
REQ-022 Load_Valid while Load_Ready low SHALL be ignored; Load_Data need not be held stable afterwards.
REQ-023 Active buffer SHALL change only at frame boundaries (no tearing within a frame).
REQ-024 Leading-zero blank: with Lz_En high, digits 0..4 with code 0 preceded only by zero codes SHALL be off; digit5 never blanked; evaluated on active buffer.
REQ-025 Digit lit condition: Scan_En & phase index <= Bright & not blanked; lit -> Dig_Sel bit of slot low, others high; unlit -> 6'b111111.
REQ-026 Number_Data and Dp_Out SHALL show active-buffer code/dp of current slot regardless of lit state; codes 10..15 passed unchanged.
REQ-027 Dig_Sel, Number_Data, Dp_Out SHALL be registered, reflecting slot/phase state one cycle later.
REQ-028 Bright = 7 SHALL give continuous lighting for the whole slot; Bright = 0 lights phase 0 only.

Reset
REQ-029 On RSTn low: counters, phase, slot, pending = 0; active/shadow buffers = 0; Load_Ready = 1; Dig_Sel = 6'b111111; Number_Data = 0; Dp_Out = 0; Frame_Start = 0.
REQ-030 Reset mid-frame or mid-handshake SHALL discard pending shadow data; first post-reset frame shows all zeros.

Structure
REQ-031 Package smg_pkg SHALL hold DIGITS = 6, CODE_W = 4, PHASES = 8, ALL_OFF = 6'b111111.
REQ-032 Phase prescaler (REQ-015/016) SHALL be sub-module smg_phase_tick, outputs phase tick and phase index.
REQ-033 Remainder (handshake, buffers, slot FSM, blanking, output registers) SHALL stay in smg_scan_sched.

Verification (T_PHASE = 3, slot = 32 cycles, frame = 192 cycles)
REQ-034 Reset release, Scan_En=1, Bright=7, Lz_En=0 -> Dig_Sel cycles 111110,111101,...,011111 each 32 cycles; Frame_Start every 192 cycles; Number_Data = 0.
REQ-035 Load 24'h123456 mid-frame -> Load_Ready low next cycle; digits unchanged until boundary; next frame Number_Data 1,2,3,4,5,6; Load_Ready high after boundary.
REQ-036 Bright=2 -> each slot Dig_Sel active 12 cycles (phases 0..2), 6'b111111 for 20 cycles.
REQ-037 Lz_En=1, Load_Data=24'h000070 -> digits 0..3 off, digit4 shows 7, digit5 shows 0 (lit).
REQ-038 Second Load_Valid while pending with 24'hABCDEF -> ignored; after boundary display shows first data; accept on exact boundary cycle displays one frame later.
REQ-039 Assert RSTn low mid-slot with pending data -> all outputs at REQ-029 values immediately; after release display shows zeros.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants, types and digit helpers for the six-digit multiplexed
// seven-segment scan scheduler.
package smg_pkg;

  localparam int DIGITS = 6;
  localparam int CODE_W = 4;
  localparam int PHASES = 8;
  localparam int PH_W   = $clog2(PHASES);
  localparam logic [DIGITS-1:0] ALL_OFF = 6'b111111;

  // Slot register is 4 bits wide so that any corrupted value decodes to a
  // defined recovery path rather than aliasing onto a live slot.
  typedef enum logic [3:0] {
    SLOT0 = 4'd0,
    SLOT1 = 4'd1,
    SLOT2 = 4'd2,
    SLOT3 = 4'd3,
    SLOT4 = 4'd4,
    SLOT5 = 4'd5
  } slot_e;

  typedef struct packed {
    logic [DIGITS*CODE_W-1:0] codes;
    logic [DIGITS-1:0]        dp;
  } frame_t;

  function automatic logic [CODE_W-1:0] digit_code(input frame_t f, input slot_e s);
    logic [CODE_W-1:0] c;
    case (s)
      SLOT0:   c = f.codes[23:20];
      SLOT1:   c = f.codes[19:16];
      SLOT2:   c = f.codes[15:12];
      SLOT3:   c = f.codes[11:8];
      SLOT4:   c = f.codes[7:4];
      SLOT5:   c = f.codes[3:0];
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic digit_dp(input frame_t f, input slot_e s);
    logic d;
    case (s)
      SLOT0:   d = f.dp[5];
      SLOT1:   d = f.dp[4];
      SLOT2:   d = f.dp[3];
      SLOT3:   d = f.dp[2];
      SLOT4:   d = f.dp[1];
      SLOT5:   d = f.dp[0];
      default: d = 1'b0;
    endcase
    return d;
  endfunction

  // Active-low one-hot select for a slot; invalid slots select nothing.
  function automatic logic [DIGITS-1:0] sel_mask(input slot_e s);
    logic [DIGITS-1:0] m;
    case (s)
      SLOT0:   m = 6'b111110;
      SLOT1:   m = 6'b111101;
      SLOT2:   m = 6'b111011;
      SLOT3:   m = 6'b110111;
      SLOT4:   m = 6'b101111;
      SLOT5:   m = 6'b011111;
      default: m = ALL_OFF;
    endcase
    return m;
  endfunction

  // Bit i set when digit i is a leading zero; the last digit is never blanked
  // so an all-zero value still shows a single 0.
  function automatic logic [DIGITS-1:0] lz_blank(input logic [DIGITS*CODE_W-1:0] codes,
                                                 input logic en);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = '0;
    run = en;
    for (int i = 0; i < DIGITS - 1; i++) begin
      run  = run && (codes[(DIGITS-1-i)*CODE_W +: CODE_W] == '0);
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/smg_phase_tick.sv
// PWM phase prescaler: divides CLK into phase ticks and tracks the 3-bit
// phase index within a digit slot.
module smg_phase_tick
  import smg_pkg::*;
#(
  parameter logic [15:0] T_PHASE = 16'd6249
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic            Tick_o,
  output logic [PH_W-1:0] Phase_o
);

  logic [15:0]     cnt_q, cnt_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            tick;

  always_comb begin
    tick    = (cnt_q == T_PHASE);
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    phase_d = tick ? phase_q + 3'd1 : phase_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign Tick_o  = tick;
  assign Phase_o = phase_q;

endmodule

// File: rtl/smg_scan_sched.sv
// Six-digit display scan scheduler: double-buffered frame load, slot
// sequencing, PWM brightness, leading-zero blanking and registered outputs.
module smg_scan_sched
  import smg_pkg::*;
#(
  parameter logic [15:0] T_PHASE = 16'd6249
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     Load_Valid,
  input  logic [DIGITS*CODE_W-1:0] Load_Data,
  input  logic [DIGITS-1:0]        Load_Dp,
  output logic                     Load_Ready,
  input  logic [PH_W-1:0]          Bright,
  input  logic                     Lz_En,
  input  logic                     Scan_En,
  output logic [DIGITS-1:0]        Dig_Sel,
  output logic [CODE_W-1:0]        Number_Data,
  output logic                     Dp_Out,
  output logic                     Frame_Start
);

  logic            tick;
  logic [PH_W-1:0] phase;

  smg_phase_tick #(
    .T_PHASE (T_PHASE)
  ) u_phase (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .Tick_o  (tick),
    .Phase_o (phase)
  );

  frame_t            shadow_q, active_q, shadow_d, active_d;
  logic              pending_q, pending_d;
  slot_e             slot_q, slot_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [CODE_W-1:0] num_q, num_d;
  logic              dp_q, dp_d;
  logic              fstart_q;

  logic              slot_adv, boundary, accept, lit;
  logic [DIGITS-1:0] blank;

  always_comb begin
    slot_adv = tick && (phase == 3'd7);
    boundary = slot_adv && (slot_q == SLOT5);
    accept   = Load_Valid && !pending_q;

    slot_d = slot_q;
    case (slot_q)
      SLOT0:   if (slot_adv) slot_d = SLOT1;
      SLOT1:   if (slot_adv) slot_d = SLOT2;
      SLOT2:   if (slot_adv) slot_d = SLOT3;
      SLOT3:   if (slot_adv) slot_d = SLOT4;
      SLOT4:   if (slot_adv) slot_d = SLOT5;
      SLOT5:   if (slot_adv) slot_d = SLOT0;
      default: slot_d = SLOT0;
    endcase
  end

  // Shadow fills only while nothing is pending, so a boundary transfer and a
  // new capture never compete; a capture on the boundary cycle waits a frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d.codes = Load_Data;
      shadow_d.dp    = Load_Dp;
      pending_d      = 1'b1;
    end
  end

  always_comb begin
    blank     = lz_blank(active_q.codes, Lz_En);
    lit       = Scan_En && (phase <= Bright);
    dig_sel_d = lit ? (sel_mask(slot_q) | blank) : ALL_OFF;
    num_d     = digit_code(active_q, slot_q);
    dp_d      = digit_dp(active_q, slot_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slot_q    <= SLOT0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      dig_sel_q <= ALL_OFF;
      num_q     <= '0;
      dp_q      <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      dig_sel_q <= dig_sel_d;
      num_q     <= num_d;
      dp_q      <= dp_d;
      fstart_q  <= boundary;
    end
  end

  assign Load_Ready  = ~pending_q;
  assign Dig_Sel     = dig_sel_q;
  assign Number_Data = num_q;
  assign Dp_Out      = dp_q;
  assign Frame_Start = fstart_q;

endmodule

// File: tb/tb_smg_scan_sched.sv
// Bench for smg_scan_sched with T_PHASE = 3 (32-cycle slots, 192-cycle frames).
module tb_smg_scan_sched;

  localparam int PH_CYC   = 4;
  localparam int SLOT_CYC = 32;
  localparam int FRAME    = 192;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Load_Valid = 1'b0;
  logic [23:0] Load_Data = '0;
  logic [5:0]  Load_Dp = '0;
  logic        Load_Ready;
  logic [2:0]  Bright = 3'd7;
  logic        Lz_En = 1'b0;
  logic        Scan_En = 1'b1;
  logic [5:0]  Dig_Sel;
  logic [3:0]  Number_Data;
  logic        Dp_Out;
  logic        Frame_Start;

  smg_scan_sched #(.T_PHASE(16'd3)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Load_Valid  (Load_Valid),
    .Load_Data   (Load_Data),
    .Load_Dp     (Load_Dp),
    .Load_Ready  (Load_Ready),
    .Bright      (Bright),
    .Lz_En       (Lz_En),
    .Scan_En     (Scan_En),
    .Dig_Sel     (Dig_Sel),
    .Number_Data (Number_Data),
    .Dp_Out      (Dp_Out),
    .Frame_Start (Frame_Start)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle count since reset release plus frame buffers.
  int unsigned t;
  logic [23:0] m_sh_d, m_act_d;
  logic [5:0]  m_sh_dp, m_act_dp;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_sh_d   = '0;
    m_act_d  = '0;
    m_sh_dp  = '0;
    m_act_dp = '0;
    m_pend   = 1'b0;
  endtask

  function automatic logic [3:0] m_digit(input int idx);
    logic [23:0] s;
    s = m_act_d >> (4 * (5 - idx));
    return s[3:0];
  endfunction

  function automatic bit m_blanked(input int idx);
    if (!Lz_En || idx == 5) return 1'b0;
    for (int j = 0; j <= idx; j++)
      if (m_digit(j) != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_sel"},   32'(Dig_Sel),     32'h3f);
    check({tag, "_num"},   32'(Number_Data), 32'h0);
    check({tag, "_dp"},    32'(Dp_Out),      32'h0);
    check({tag, "_fs"},    32'(Frame_Start), 32'h0);
    check({tag, "_ready"}, 32'(Load_Ready),  32'h1);
  endtask

  task automatic cycle();
    int         ph, sl;
    bit         lit, bnd, acc;
    logic [5:0] e_sel;
    logic [3:0] e_num;
    logic       e_dp;
    @(posedge CLK);
    ph    = int'((t / PH_CYC) % 8);
    sl    = int'((t / SLOT_CYC) % 6);
    bnd   = ((t + 1) % FRAME) == 0;
    lit   = Scan_En && (ph <= int'(Bright)) && !m_blanked(sl);
    e_sel = 6'h3f;
    if (lit) e_sel[sl] = 1'b0;
    e_num = m_digit(sl);
    e_dp  = m_act_dp[5 - sl];
    acc   = Load_Valid && !m_pend;
    if (bnd && m_pend) begin
      m_act_d  = m_sh_d;
      m_act_dp = m_sh_dp;
      m_pend   = 1'b0;
    end
    if (acc) begin
      m_sh_d  = Load_Data;
      m_sh_dp = Load_Dp;
      m_pend  = 1'b1;
    end
    t++;
    #1;
    check("dig_sel", 32'(Dig_Sel),     32'(e_sel));
    check("number",  32'(Number_Data), 32'(e_num));
    check("dp",      32'(Dp_Out),      32'(e_dp));
    check("frame_st", 32'(Frame_Start), 32'(bnd));
    check("ready",   32'(Load_Ready),  32'(!m_pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [23:0] d, input logic [5:0] dp);
    Load_Valid = 1'b1;
    Load_Data  = d;
    Load_Dp    = dp;
    cycle();
    Load_Valid = 1'b0;
    Load_Data  = 24'($urandom);
    Load_Dp    = 6'($urandom);
  endtask

  task automatic run_to_frame_pos(input int pos);
    for (int g = 0; g < FRAME && int'(t % FRAME) != pos; g++) cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_reset("rst_init");
    @(negedge CLK);
    RSTn = 1'b1;

    // Free-running scan, all zeros, full brightness.
    run(400);

    // Mid-frame load becomes visible only from the next frame.
    run_to_frame_pos(70);
    load(24'h123456, 6'b100001);
    run(420);

    // Reduced brightness.
    Bright = 3'd2;
    run(200);
    Bright = 3'd0;
    run(100);
    Bright = 3'd7;

    // Leading-zero suppression.
    Lz_En = 1'b1;
    run_to_frame_pos(20);
    load(24'h000070, 6'b000000);
    run(400);
    load(24'h000000, 6'b010101);
    run(400);

    // Second offer while pending is ignored.
    run_to_frame_pos(40);
    load(24'h9AF0C1, 6'b111000);
    load(24'hABCDEF, 6'b000111);
    run(5);
    load(24'hABCDEF, 6'b000111);
    run_to_frame_pos(5);

    // Accept on the exact boundary cycle waits one more frame.
    Lz_En = 1'b0;
    run_to_frame_pos(FRAME - 1);
    load(24'hFEDCBA, 6'b101010);
    run(400);

    // Randomized loads, brightness, blanking and enable.
    for (int k = 0; k < 25; k++) begin
      logic [23:0] d;
      Bright  = 3'($urandom_range(0, 7));
      Lz_En   = 1'($urandom_range(0, 1));
      Scan_En = ($urandom_range(0, 3) != 0);
      d = 24'($urandom);
      if ($urandom_range(0, 1) == 1) d = d & (24'hffffff >> (4 * $urandom_range(1, 6)));
      load(d, 6'($urandom));
      run(int'($urandom_range(20, 250)));
    end

    // Reset in the middle of a slot with pending shadow data.
    Scan_En = 1'b1;
    Bright  = 3'd7;
    Lz_En   = 1'b0;
    run_to_frame_pos(10);
    load(24'h135792, 6'b111111);
    run(37);
    RSTn = 1'b0;
    #1;
    check_reset("rst_mid");
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
    run(420);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
